// File: rtl/rf_access_bridge_pkg.sv
// Shared types and constants for the register-file access bridge.
//   state_e        : bridge FSM states
//   RSP_*          : response status encodings
//   Default*       : default parameter values
package rf_access_bridge_pkg;

  localparam int unsigned DefaultAddrW   = 4;
  localparam int unsigned DefaultDataW   = 64;
  localparam int unsigned DefaultTimeout = 16;

  localparam logic [1:0] RSP_OK           = 2'b00;
  localparam logic [1:0] RSP_INVALID_ADDR = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT      = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/rf_access_bridge_if.sv
// Bundle of the command channel, response channel and RF port of the bridge.
//   slave  : the bridge's view (accepts commands, drives responses and RF strobes)
//   master : the environment's view (issues commands, consumes responses, acts as RF)
interface rf_access_bridge_if
  import rf_access_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW
);

  // Command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  // Response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_status;
  logic              rsp_write;
  logic [ADDR_W-1:0] rsp_addr;

  // Register-file port
  logic [ADDR_W-1:0] rf_address;
  logic [DATA_W-1:0] rf_write_data;
  logic              rf_read_en;
  logic              rf_write_en;
  logic [DATA_W-1:0] rf_read_data;
  logic              rf_invalid_address;
  logic              rf_access_complete;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           rf_read_data, rf_invalid_address, rf_access_complete,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_status, rsp_write, rsp_addr,
           rf_address, rf_write_data, rf_read_en, rf_write_en
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           rf_read_data, rf_invalid_address, rf_access_complete,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_status, rsp_write, rsp_addr,
           rf_address, rf_write_data, rf_read_en, rf_write_en
  );

endinterface

// File: rtl/rf_access_bridge.sv
// Serialises single read/write commands into the register file. Each accepted
// command becomes a one-cycle RF strobe, then the bridge waits (bounded by
// TIMEOUT cycles) for rf_access_complete and returns data plus status.
//   clk_hmc, rst_hmc : clock, synchronous active-high reset
//   bus              : command / response / RF signals (slave modport)
//   timeout_count    : saturating count of timed-out accesses
module rf_access_bridge
  import rf_access_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefaultAddrW,
  parameter int unsigned DATA_W  = DefaultDataW,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic                clk_hmc,
  input  logic                rst_hmc,
  rf_access_bridge_if.slave   bus,
  output logic [7:0]          timeout_count
);

  // The counter value compared is the post-increment one, so the response
  // rises exactly TIMEOUT cycles after the strobe cycle.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic [7:0]        to_cnt_q, to_cnt_d;
  logic              cap_write_q, cap_write_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              rf_read_en_q, rf_read_en_d;
  logic              rf_write_en_q, rf_write_en_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_status_q, rsp_status_d;
  logic              rsp_write_q, rsp_write_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [7:0]        wait_cnt_inc;

  assign wait_cnt_inc = wait_cnt_q + 8'd1;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    to_cnt_d      = to_cnt_q;
    cap_write_d   = cap_write_q;
    rf_addr_d     = rf_addr_q;
    rf_wdata_d    = rf_wdata_q;
    rf_read_en_d  = 1'b0;
    rf_write_en_d = 1'b0;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_status_d  = rsp_status_q;
    rsp_write_d   = rsp_write_q;
    rsp_addr_d    = rsp_addr_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          cap_write_d   = bus.cmd_write;
          rf_addr_d     = bus.cmd_addr;
          rf_wdata_d    = bus.cmd_wdata;
          // Strobe is registered so it lands in the ISSUE cycle.
          rf_write_en_d = bus.cmd_write;
          rf_read_en_d  = ~bus.cmd_write;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        // Any complete seen here belongs to an earlier access and is ignored.
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        wait_cnt_d = wait_cnt_inc;
        if (bus.rf_access_complete || (wait_cnt_inc == TimeoutLast)) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = cap_write_q;
          rsp_addr_d  = rf_addr_q;
          rf_addr_d   = '0;
          rf_wdata_d  = '0;
          state_d     = StResp;
          if (bus.rf_access_complete) begin
            rsp_status_d = bus.rf_invalid_address ? RSP_INVALID_ADDR : RSP_OK;
            rsp_rdata_d  = (!cap_write_q && !bus.rf_invalid_address) ? bus.rf_read_data : '0;
          end else begin
            rsp_status_d = RSP_TIMEOUT;
            rsp_rdata_d  = '0;
            if (to_cnt_q != 8'hFF) to_cnt_d = to_cnt_q + 8'd1;
          end
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d  = 1'b0;
          rsp_rdata_d  = '0;
          rsp_status_d = RSP_OK;
          rsp_write_d  = 1'b0;
          rsp_addr_d   = '0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_hmc) begin
    if (rst_hmc) begin
      state_q       <= StIdle;
      wait_cnt_q    <= '0;
      to_cnt_q      <= '0;
      cap_write_q   <= 1'b0;
      rf_addr_q     <= '0;
      rf_wdata_q    <= '0;
      rf_read_en_q  <= 1'b0;
      rf_write_en_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_status_q  <= RSP_OK;
      rsp_write_q   <= 1'b0;
      rsp_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      to_cnt_q      <= to_cnt_d;
      cap_write_q   <= cap_write_d;
      rf_addr_q     <= rf_addr_d;
      rf_wdata_q    <= rf_wdata_d;
      rf_read_en_q  <= rf_read_en_d;
      rf_write_en_q <= rf_write_en_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_status_q  <= rsp_status_d;
      rsp_write_q   <= rsp_write_d;
      rsp_addr_q    <= rsp_addr_d;
    end
  end

  assign bus.cmd_ready     = (state_q == StIdle);
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.rsp_status    = rsp_status_q;
  assign bus.rsp_write     = rsp_write_q;
  assign bus.rsp_addr      = rsp_addr_q;
  assign bus.rf_address    = rf_addr_q;
  assign bus.rf_write_data = rf_wdata_q;
  assign bus.rf_read_en    = rf_read_en_q;
  assign bus.rf_write_en   = rf_write_en_q;
  assign timeout_count     = to_cnt_q;

endmodule

// File: tb/tb_rf_access_bridge.sv
// Randomised bench for rf_access_bridge. The bench plays the register file
// (a small array; addresses >= InvalidBase are rejected) and predicts every
// response from the command, the chosen completion delay and the array.
module tb_rf_access_bridge;
  import rf_access_bridge_pkg::*;

  localparam int unsigned TIMEOUT     = 16;
  localparam int unsigned InvalidBase = 14;

  logic       clk_hmc = 1'b0;
  logic       rst_hmc;
  logic [7:0] timeout_count;

  rf_access_bridge_if #(.ADDR_W(4), .DATA_W(64)) ifc ();

  rf_access_bridge #(
    .ADDR_W (4),
    .DATA_W (64),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_hmc      (clk_hmc),
    .rst_hmc      (rst_hmc),
    .bus          (ifc),
    .timeout_count(timeout_count)
  );

  always #5 clk_hmc = ~clk_hmc;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] mem [16];
  int          exp_to = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_hmc);
    #1;
  endtask

  task automatic idle_inputs();
    ifc.cmd_valid          = 1'b0;
    ifc.cmd_write          = 1'b0;
    ifc.cmd_addr           = '0;
    ifc.cmd_wdata          = '0;
    ifc.rsp_ready          = 1'b0;
    ifc.rf_read_data       = '0;
    ifc.rf_invalid_address = 1'b0;
    ifc.rf_access_complete = 1'b0;
  endtask

  // Cycle t counts from the strobe cycle (t = 0). The RF completes at t = d
  // (d = 0 is stale and ignored); the consumer takes the response rdy_dly
  // cycles after it appears. hold keeps cmd_valid asserted while busy.
  task automatic run_txn(input bit wr, input logic [3:0] addr, input logic [63:0] wd,
                         input int d, input int rdy_dly, input bit hold);
    bit          timed_out, inval;
    int          rsp_t, hs_t, last_t;
    logic [1:0]  exp_st;
    logic [63:0] exp_rd;
    check("idle_cmd_ready", ifc.cmd_ready, 1'b1);
    check("idle_rsp_valid", ifc.rsp_valid, 1'b0);
    check("timeout_count_before", timeout_count, exp_to);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_write = wr;
    ifc.cmd_addr  = addr;
    ifc.cmd_wdata = wd;
    step();
    inval     = (addr >= InvalidBase);
    timed_out = !(d >= 1 && d <= int'(TIMEOUT) - 1);
    rsp_t     = timed_out ? int'(TIMEOUT) : d + 1;
    hs_t      = rsp_t + rdy_dly;
    last_t    = (hs_t + 1 > d) ? hs_t + 1 : d;
    exp_st    = timed_out ? RSP_TIMEOUT : (inval ? RSP_INVALID_ADDR : RSP_OK);
    exp_rd    = (exp_st == RSP_OK && !wr) ? mem[addr] : 64'd0;
    if (timed_out && exp_to != 255) exp_to++;
    for (int t = 0; t <= last_t; t++) begin
      ifc.cmd_valid          = hold && (t <= hs_t);
      ifc.rf_access_complete = (t == d);
      ifc.rf_invalid_address = (t == d) && inval;
      ifc.rf_read_data       = (t == d && !inval) ? mem[addr] : {$urandom, $urandom};
      ifc.rsp_ready          = (t == hs_t);
      if (t == d && wr && !inval) mem[addr] = wd;
      check("rf_write_en", ifc.rf_write_en, (t == 0) && wr);
      check("rf_read_en", ifc.rf_read_en, (t == 0) && !wr);
      check("cmd_ready", ifc.cmd_ready, t > hs_t);
      check("rsp_valid", ifc.rsp_valid, (t >= rsp_t) && (t <= hs_t));
      check("rf_address", ifc.rf_address, (t < rsp_t) ? addr : 4'd0);
      check("rf_write_data", ifc.rf_write_data, (t < rsp_t) ? wd : 64'd0);
      if (t >= rsp_t && t <= hs_t) begin
        check("rsp_status", ifc.rsp_status, exp_st);
        check("rsp_rdata", ifc.rsp_rdata, exp_rd);
        check("rsp_write", ifc.rsp_write, wr);
        check("rsp_addr", ifc.rsp_addr, addr);
        check("timeout_count", timeout_count, exp_to);
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
    idle_inputs();
    rst_hmc = 1'b1;
    repeat (3) step();
    rst_hmc = 1'b0;

    check("rst_cmd_ready", ifc.cmd_ready, 1'b1);
    check("rst_rsp_valid", ifc.rsp_valid, 1'b0);
    check("rst_rf_strobes", {ifc.rf_read_en, ifc.rf_write_en}, 2'b00);
    check("rst_rf_address", ifc.rf_address, 4'd0);
    check("rst_rsp_rdata", ifc.rsp_rdata, 64'd0);
    check("rst_timeout_count", timeout_count, 8'd0);

    // Directed scenarios
    run_txn(1'b1, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1'b0);
    check("mem_model_addr2", mem[2], 64'hFFFF_FFFF_FFFF_FFFF);
    run_txn(1'b0, 4'd2, 64'd0, 1, 0, 1'b0);
    run_txn(1'b0, 4'd15, 64'd0, 3, 0, 1'b0);
    run_txn(1'b0, 4'd5, 64'd0, TIMEOUT + 2, 0, 1'b0);  // complete arrives late, in IDLE
    run_txn(1'b0, 4'd6, 64'd0, TIMEOUT - 1, 1, 1'b0);  // complete coincides with timeout
    run_txn(1'b1, 4'd7, 64'h1234_5678_9ABC_DEF0, 2, 5, 1'b1);
    run_txn(1'b0, 4'd7, 64'd0, 4, 5, 1'b1);

    // Reset in the middle of a WAIT
    ifc.cmd_valid = 1'b1;
    ifc.cmd_write = 1'b0;
    ifc.cmd_addr  = 4'd3;
    step();
    ifc.cmd_valid = 1'b0;
    repeat (3) step();
    rst_hmc = 1'b1;
    step();
    rst_hmc = 1'b0;
    exp_to  = 0;
    check("midrst_cmd_ready", ifc.cmd_ready, 1'b1);
    check("midrst_rsp_valid", ifc.rsp_valid, 1'b0);
    check("midrst_strobes", {ifc.rf_read_en, ifc.rf_write_en}, 2'b00);
    check("midrst_rf_address", ifc.rf_address, 4'd0);
    check("midrst_timeout_count", timeout_count, 8'd0);
    for (int i = 0; i < 4; i++) begin
      ifc.rf_access_complete = (i == 1);
      check("midrst_no_rsp", ifc.rsp_valid, 1'b0);
      step();
    end
    idle_inputs();
    run_txn(1'b0, 4'd3, 64'd0, 2, 0, 1'b0);

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      run_txn(1'($urandom), 4'($urandom), {$urandom, $urandom},
              int'($urandom_range(0, TIMEOUT + 3)), int'($urandom_range(0, 3)),
              1'($urandom));
    end

    // Drive the timeout counter into saturation
    for (int n = 0; n < 260; n++) begin
      run_txn(1'b0, 4'($urandom), 64'd0, 0, 0, 1'b0);
    end
    check("timeout_count_saturated", timeout_count, 8'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_access_bridge.md
# rf_access_bridge

Command-to-register-file bridge sitting directly upstream of the openHMC register file (RF) port. It accepts single read/write commands on a valid/ready channel and converts each into a one-cycle `rf_read_en`/`rf_write_en` strobe. It then waits for `rf_access_complete`, with a timeout, and returns data plus status on a valid/ready response channel. One access is outstanding at a time; the block serialises all software/config traffic into the RF.

## Interface
- `ADDR_W`, default 4: RF address width.
- `DATA_W`, default 64: RF data width.
- `TIMEOUT`, default 16: cycles waited for `rf_access_complete` before aborting (legal range 2..255).

Ports:
- `clk_hmc`  in  1  the single clock; everything is on its rising edge.
- `rst_hmc`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  bridge accepts a command.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W  target address.
- `cmd_wdata`  in  DATA_W  write data (ignored for reads).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  DATA_W  read data; 0 for writes and for non-OK status.
- `rsp_status`  out  2  00 OK, 01 INVALID_ADDR, 10 TIMEOUT (11 unused).
- `rsp_write`  out  1  echo of `cmd_write`.
- `rsp_addr`  out  ADDR_W  echo of `cmd_addr`.
- `rf_address`  out  ADDR_W  to RF.
- `rf_write_data`  out  DATA_W  to RF.
- `rf_read_en`  out  1  read strobe to RF.
- `rf_write_en`  out  1  write strobe to RF.
- `rf_read_data`  in  DATA_W  from RF.
- `rf_invalid_address`  in  1  from RF, qualified by `rf_access_complete`.
- `rf_access_complete`  in  1  from RF, access finished.
- `timeout_count`  out  8  number of timed-out accesses, saturating at 255.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `cmd_ready` = 1, driven combinationally from the state.
  - On `cmd_valid & cmd_ready`, capture write, addr and wdata, then go to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - Assert `rf_write_en` if write, otherwise `rf_read_en`; never both.
  - Clear the wait counter and go to WAIT.
  - `rf_access_complete` seen in this cycle is ignored as stale.
- **WAIT**
  - Strobes are low. The wait counter increments each cycle.
  - On `rf_access_complete`:
    - status = INVALID_ADDR if `rf_invalid_address`, else OK.
    - `rsp_rdata` = `rf_read_data` only for a read with OK status, else 0.
    - Go to RESP.
  - Otherwise, when the counter reaches `TIMEOUT-1`:
    - status = TIMEOUT, rdata = 0.
    - `timeout_count` += 1, saturating.
    - Go to RESP.
  - If complete and the timeout occur in the same cycle, complete wins.
- **RESP**
  - `rsp_valid` = 1. The payload stays stable until `rsp_ready`; on that handshake go to IDLE.
- `rf_address` and `rf_write_data` hold the captured values during ISSUE and WAIT. They are 0 in IDLE and RESP.
- `rf_access_complete` arriving in RESP or IDLE (late, after a timeout) is ignored and produces no response.

## Timing
- Reset values:
  - state IDLE.
  - `cmd_ready` 1.
  - `rsp_valid`, `rsp_*`, `rf_*` outputs all 0.
  - `timeout_count` 0.
- Reset asserted mid-operation:
  - Strobes and `rsp_valid` are low from the next edge.
  - The outstanding command is dropped with no response.
- Command accepted at edge N:
  - Strobe is high in cycle N+1.
  - The earliest usable complete is in cycle N+2.
  - `rsp_valid` is high from N+3.
- Minimum turnaround is 4 cycles per command with `rsp_ready` held high. The next `cmd_ready` is in the cycle after the response handshake.
- With no complete, `rsp_valid` rises `TIMEOUT` cycles after the strobe cycle.
- All outputs are registered except `cmd_ready`.

## Structure
- Package `rf_access_bridge_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - the status constants `RSP_OK`, `RSP_INVALID_ADDR`, `RSP_TIMEOUT`;
  - default widths.
- No sub-module. The timeout and saturating counters are inline; they are too small to split out.

## Test plan
- Write addr 2, data all-ones; RF completes 1 cycle after the strobe -> `rf_write_en` high for exactly 1 cycle, `rf_address`=2, response OK with rdata 0 at N+3.
- Read addr 2 after that write -> `rf_read_en` pulse; response OK, `rsp_rdata`=64'hFFFF_FFFF_FFFF_FFFF, `rsp_addr`=2.
- Read addr 15 with `rf_invalid_address`=1 on complete -> status 01, rdata 0.
- RF never completes, `TIMEOUT`=16 -> status 10, `rsp_valid` 16 cycles after the strobe, `timeout_count`=1. A late complete afterwards is ignored.
- Hold `rsp_ready`=0 for 5 cycles while `cmd_valid` is held -> payload stable, `cmd_ready`=0, no second strobe until the handshake.
- Assert `rst_hmc` during WAIT -> no response; all outputs at reset values on the next edge; the next command behaves normally.
